// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage ALU. Legacy ops finish in one cycle; multiply,
// divide and remainder iterate one bit per cycle behind Start/Busy/Done.
//
// Handshake: a request is taken on a rising edge where Start=1 and Busy=0.
// Operands and ALU_Control are sampled only at that edge. Done pulses for one
// cycle when ALU_Result/Zero update, and the outputs then hold until the next
// Done. Start while Busy=1 is dropped, not queued.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] RD1,
  input  logic [WIDTH-1:0] RD2,
  input  logic [4:0]       ALU_Control,
  output logic [WIDTH-1:0] ALU_Result,
  output logic             Zero,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       o_state
);

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_LUI   = 5'b11111;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_AND   = 5'b11100;
  localparam logic [4:0] OP_XOR   = 5'b10000;
  localparam logic [4:0] OP_SLL   = 5'b00100;
  localparam logic [4:0] OP_SRL   = 5'b10100;
  localparam logic [4:0] OP_SRA   = 5'b10110;
  localparam logic [4:0] OP_MUL   = 5'b01000;
  localparam logic [4:0] OP_MULH  = 5'b01001;
  localparam logic [4:0] OP_MULHU = 5'b01010;
  localparam logic [4:0] OP_DIV   = 5'b01100;
  localparam logic [4:0] OP_DIVU  = 5'b01101;
  localparam logic [4:0] OP_REM   = 5'b01110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SHW-1:0]         r_cnt;
  logic [2*WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]       r_b;
  logic [4:0]             r_op;
  logic                   r_neg_q;
  logic                   r_neg_r;
  logic [WIDTH-1:0]       r_result;
  logic                   r_zero;
  logic                   r_done;

  logic                   w_is_mul;
  logic                   w_is_div;
  logic                   w_signed;
  logic                   w_a_neg;
  logic                   w_b_neg;
  logic [WIDTH-1:0]       w_a_mag;
  logic [WIDTH-1:0]       w_b_mag;
  logic                   w_div_zero;
  logic                   w_div_ovf;
  logic                   w_iter_path;
  logic [SHW-1:0]         w_shamt;
  logic [WIDTH-1:0]       w_single_res;
  logic [WIDTH:0]         w_mul_add;
  logic [WIDTH:0]         w_div_trial;
  logic [2*WIDTH-1:0]     w_step;
  logic [2*WIDTH-1:0]     w_prod;
  logic [WIDTH-1:0]       w_quo;
  logic [WIDTH-1:0]       w_rem;
  logic [WIDTH-1:0]       w_fix_res;

  assign ALU_Result = r_result;
  assign Zero       = r_zero;
  assign Done       = r_done;
  assign Busy       = (r_state != S_IDLE);
  assign o_state    = r_state;

  // Decode the request and prepare magnitudes / special divide cases.
  always_comb begin
    w_is_mul    = (ALU_Control == OP_MUL) || (ALU_Control == OP_MULH) ||
                  (ALU_Control == OP_MULHU);
    w_is_div    = (ALU_Control[4:2] == 3'b011);
    w_signed    = (ALU_Control == OP_MUL) || (ALU_Control == OP_MULH) ||
                  (ALU_Control == OP_DIV) || (ALU_Control == OP_REM);
    w_a_neg     = w_signed && RD1[WIDTH-1];
    w_b_neg     = w_signed && RD2[WIDTH-1];
    w_a_mag     = w_a_neg ? (-RD1) : RD1;
    w_b_mag     = w_b_neg ? (-RD2) : RD2;
    w_div_zero  = w_is_div && (RD2 == '0);
    w_div_ovf   = ((ALU_Control == OP_DIV) || (ALU_Control == OP_REM)) &&
                  (RD1 == {1'b1, {(WIDTH-1){1'b0}}}) && (RD2 == '1);
    w_iter_path = w_is_mul || (w_is_div && !w_div_zero && !w_div_ovf);
    w_shamt     = RD2[SHW-1:0];
  end

  // Single-cycle result: legacy ops plus the divide corner cases.
  always_comb begin
    w_single_res = '0;
    case (ALU_Control)
      OP_ADD, OP_LUI: w_single_res = RD1 + RD2;
      OP_SUB:         w_single_res = RD1 - RD2;
      OP_AND:         w_single_res = RD1 & RD2;
      OP_XOR:         w_single_res = RD1 ^ RD2;
      OP_SLL:         w_single_res = RD1 << w_shamt;
      OP_SRL:         w_single_res = RD1 >> w_shamt;
      OP_SRA:         w_single_res = $signed(RD1) >>> w_shamt;
      default:        w_single_res = '0;
    endcase
    // Bit 1 of the code separates REM/REMU from DIV/DIVU.
    if (w_div_zero) begin
      w_single_res = ALU_Control[1] ? RD1 : '1;
    end else if (w_div_ovf) begin
      w_single_res = ALU_Control[1] ? '0 : RD1;
    end
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    w_mul_add   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                  (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
    if (r_op[2]) begin
      if (!w_div_trial[WIDTH]) begin
        w_step = {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
        w_step = {r_acc[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      w_step = {w_mul_add, r_acc[WIDTH-1:1]};
    end
  end

  // Sign correction and half/quotient/remainder selection at the end.
  always_comb begin
    w_prod = r_neg_q ? (-r_acc) : r_acc;
    w_quo  = r_neg_q ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    w_rem  = r_neg_r ? (-r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
    case (r_op)
      OP_MUL:           w_fix_res = w_prod[WIDTH-1:0];
      OP_MULH, OP_MULHU: w_fix_res = w_prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:  w_fix_res = w_quo;
      default:          w_fix_res = w_rem;
    endcase
  end

  // Next-state logic for IDLE -> ITER -> FIX -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (Start && w_iter_path) w_state_nxt = S_ITER;
      S_ITER:  if (r_cnt == '0) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and datapath; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            if (w_iter_path) begin
              r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
              r_b     <= w_b_mag;
              r_op    <= ALU_Control;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_cnt   <= SHW'(WIDTH-1);
            end else begin
              r_result <= w_single_res;
              r_zero   <= (w_single_res == '0);
              r_done   <= 1'b1;
            end
          end
        end
        S_ITER: begin
          r_acc <= w_step;
          if (r_cnt != '0) r_cnt <= r_cnt - SHW'(1);
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_zero   <= (w_fix_res == '0);
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised, multi-cycle successor to the single-cycle datapath ALU. It executes every existing ALU operation with single-cycle latency, using the same 5-bit control codes. It adds iterative RV32M-style multiply, divide and remainder behind a Start/Busy/Done handshake. It sits in the execute stage, and the control unit stalls the pipeline while Busy is high.

## Interface
- WIDTH, 32: operand/result width; must be a power of two, ≥ 8.
- SHW, $clog2(WIDTH): shift-amount width (derived; do not override).
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- Start  in  1  operation request; accepted only when Busy = 0.
- RD1  in  WIDTH  operand A (signed interpretation unless the op is unsigned).
- RD2  in  WIDTH  operand B.
- ALU_Control  in  5  operation select; sampled together with operands on acceptance.
- ALU_Result  out  WIDTH  registered result; held until the next Done.
- Zero  out  1  registered, = (ALU_Result == 0).
- Busy  out  1  high from acceptance until the cycle Done is asserted (inclusive of the iterating cycles, exclusive of the Done cycle).
- Done  out  1  one-cycle pulse; ALU_Result/Zero are valid from this cycle on.

## Operation
- Legacy codes, single-cycle:
  - 00000 ADD; 11111 LUI (add); 00010 SUB; 11100 AND; 10000 XOR.
  - 00100 SLL; 10100 SRL (logical); 10110 SRA (arithmetic).
  - Shift amount = RD2[SHW-1:0]; upper RD2 bits are ignored.
- New codes, iterative:
  - 01000 MUL: low WIDTH bits of the product.
  - 01001 MULH: high WIDTH bits, signed×signed.
  - 01010 MULHU: high WIDTH bits, unsigned×unsigned.
  - 01100 DIV, 01101 DIVU: quotient, signed/unsigned, truncated toward zero.
  - 01110 REM, 01111 REMU: remainder; sign of the result follows the dividend.
- Any other code completes in one cycle with result 0 and Zero = 1.
- FSM states: IDLE, ITER, FIX.
  - IDLE + Start, single-cycle op: result registered, Done = 1 next cycle, stay IDLE.
  - IDLE + Start, iterative op: latch operands and op; convert signed operands to magnitudes and record the result sign; go to ITER with counter = WIDTH-1.
  - ITER: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; 2·WIDTH-bit accumulator. When counter = 0, go to FIX; otherwise decrement.
  - FIX: apply two's-complement sign correction, select the high/low half or quotient/remainder, write ALU_Result, pulse Done, return to IDLE.
- Divide special cases, resolved in IDLE and taking the single-cycle path (no iteration):
  - Divisor 0: DIV/DIVU → all-ones; REM/REMU → RD1.
  - Signed overflow (RD1 = most-negative, RD2 = -1): DIV → most-negative; REM → 0.
- Start while Busy = 1 is ignored; operands and ALU_Control changing during Busy have no effect.
- Start in the same cycle as Done (state IDLE) is accepted normally (back-to-back issue).

## Timing
- Reset (rst_n = 0 at an edge): state IDLE, ALU_Result = 0, Zero = 1, Busy = 0, Done = 0, counter = 0, internal accumulators = 0.
- Reset has priority over Start and aborts an in-flight ITER/FIX; no Done is produced for the aborted operation.
- Single-cycle op accepted at edge N: Done = 1 during cycle N→N+1 (latency 1); Busy stays 0.
- Iterative op accepted at edge N: Busy = 1 from N to N+WIDTH+1.
  - WIDTH ITER edges (N+1 … N+WIDTH), then FIX at edge N+WIDTH+1.
  - Done = 1 and Busy = 0 after edge N+WIDTH+1; latency WIDTH+1 (33 at WIDTH = 32).
- Done is never high for two consecutive cycles unless two single-cycle ops are issued back-to-back.
- ALU_Result and Zero change only on a Done edge or on reset.

## Test plan
- Reset/legacy: hold rst_n = 0 for 2 cycles → all outputs at reset values. Then ADD 5+(-7) → ALU_Result = 0xFFFFFFFE, Zero = 0, Done one cycle later. SUB 9-9 → Zero = 1. SRA 0x80000000 by RD2 = 0x24 (shift 4) → 0xF8000000.
- Multiply: MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001. MULH of the same operands → 0x00000000. MULHU of the same operands → 0xFFFFFFFE. Done exactly 33 cycles after acceptance; Busy high for 33 cycles.
- Divide: DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2. Each takes 33 cycles.
- Corner cases: DIV x/0 → 0xFFFFFFFF; REMU 13/0 → 13; DIV 0x80000000/-1 → 0x80000000; REM of the same → 0, Zero = 1. All four complete with 1-cycle latency.
- Handshake: pulse Start with new operands at cycles 5 and 20 of an in-flight MUL → ignored; the result matches the original operands. Start in the Done cycle → accepted immediately.
- Reset mid-op: drop rst_n at ITER cycle 10 of a DIVU → no Done; outputs at reset values. The next DIVU 100/7 → 14 with full latency.
